// File: rtl/tick_uart_tx_if.sv
// tick_uart_tx_if: valid/ready word channel feeding the tick-paced UART transmitter
interface tick_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/tick_uart_tx.sv
// tick_uart_tx: tick-paced UART transmitter, LSB-first, optional parity, 1 or 2 stop bits
module tick_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          tick,
  tick_uart_tx_if.slave bus,
  output logic          tx,
  output logic          tx_busy
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic ODD = PARITY_ODD != 0;
  localparam logic HAS_PAR = PARITY_EN != 0;
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] sr, sr_nx;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic stop_cnt, stop_cnt_nx;
  logic par, par_nx;
  logic tx_nx;
  // state, shift register, counters and the registered line
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      bit_cnt  <= bit_cnt_nx;
      stop_cnt <= stop_cnt_nx;
      par      <= par_nx;
      tx       <= tx_nx;
    end
  end
  // frame sequencing; parity is taken from the still-unshifted word while arming
  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    bit_cnt_nx  = bit_cnt;
    stop_cnt_nx = stop_cnt;
    par_nx      = par;
    tx_nx       = tx;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (bus.tx_valid) begin
          sr_nx    = bus.tx_data;
          state_nx = ARM;
        end
      end
      ARM: if (tick) begin
        tx_nx    = 1'b0;
        par_nx   = (^sr) ^ ODD;
        state_nx = START;
      end
      START: if (tick) begin
        tx_nx      = sr[0];
        bit_cnt_nx = '0;
        state_nx   = DATA;
      end
      DATA: if (tick) begin
        if (bit_cnt != LAST_BIT) begin
          sr_nx      = sr >> 1;
          tx_nx      = sr[1];
          bit_cnt_nx = bit_cnt + CW'(1);
        end else if (HAS_PAR) begin
          tx_nx    = par;
          state_nx = PARITY;
        end else begin
          tx_nx       = 1'b1;
          stop_cnt_nx = 1'b0;
          state_nx    = STOP;
        end
      end
      PARITY: if (tick) begin
        tx_nx       = 1'b1;
        stop_cnt_nx = 1'b0;
        state_nx    = STOP;
      end
      STOP: if (tick) begin
        state_nx    = stop_cnt == LAST_STOP ? IDLE : STOP;
        stop_cnt_nx = stop_cnt == LAST_STOP ? stop_cnt : 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign bus.tx_ready = state == IDLE;
  assign tx_busy      = state != IDLE;
endmodule
